stop_watch_ctrl: RTL and testbench

Sequencing controller for the stopwatch datapath. It owns the run/pause/clear control of the BCD time counters and a small lap memory. It also arbitrates which value drives the 4-digit FND controller: live time, a frozen lap, or a stored lap under review. It sits between the debounced button edge pulses and the counter/time-base chain, and feeds `value` to `fnd_4digit_cntr`.

---
 rtl/stop_watch_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_stop_watch_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/stop_watch_ctrl.sv
// stop_watch_ctrl: run/pause/clear sequencing for the stopwatch counters,
// a small ring of lap captures, and selection of the value shown on the FND.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   IDLE     | stopped at power-up or after clear; live time shown
//   RUN      | time base gated into counters; live time shown
//   LAP_HOLD | still counting; display frozen on the latest lap capture
//   PAUSE    | counting stopped; live (frozen) time shown
//   REVIEW   | counting stopped; stepping through stored laps, newest first
//
// Every output is a register. The next-state logic also computes the value
// that each output will carry in the following cycle, so a button pulse
// sampled at one edge is fully reflected right after that edge.
module stop_watch_ctrl #(
  parameter int LAP_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        btn_start,
  input  logic        btn_lap,
  input  logic        btn_clear,
  input  logic [15:0] live_value,
  output logic        count_en,
  output logic        count_clr,
  output logic [15:0] value,
  output logic        lap,
  output logic [3:0]  lap_count,
  output logic [3:0]  lap_sel,
  output logic [2:0]  state
);

  localparam int PTR_W = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1;
  localparam logic [3:0] DEPTH_CNT = 4'(LAP_DEPTH);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RUN      = 3'd1,
    LAP_HOLD = 3'd2,
    PAUSE    = 3'd3,
    REVIEW   = 3'd4
  } state_t;

  state_t             state_q;
  state_t             state_d;

  logic [PTR_W-1:0]   wr_ptr_q;
  logic [15:0]        hold_q;
  logic [15:0]        mem [LAP_DEPTH];

  logic               clr_d;
  logic               empty_d;
  logic               capture;
  logic [3:0]         sel_d;
  logic               en_d;
  logic               lap_d;
  logic [15:0]        value_d;
  logic [PTR_W-1:0]   rd_idx;

  // Next state, pending actions and next lap selection; clear > start > lap.
  always_comb begin
    state_d = state_q;
    clr_d   = 1'b0;
    empty_d = 1'b0;
    capture = 1'b0;
    sel_d   = 4'd0;

    case (state_q)
      IDLE: begin
        if (btn_clear) begin
          clr_d   = 1'b1;
          empty_d = 1'b1;
        end else if (btn_start) begin
          state_d = RUN;
        end
      end

      RUN: begin
        // Clear has no meaning while counting, so it does not mask start/lap.
        if (btn_start) begin
          state_d = PAUSE;
        end else if (btn_lap) begin
          capture = 1'b1;
          state_d = LAP_HOLD;
        end
      end

      LAP_HOLD: begin
        if (btn_clear) begin
          state_d = RUN;
        end else if (btn_start) begin
          state_d = PAUSE;
        end else if (btn_lap) begin
          capture = 1'b1;
        end
      end

      PAUSE: begin
        if (btn_clear) begin
          clr_d   = 1'b1;
          empty_d = 1'b1;
          state_d = IDLE;
        end else if (btn_start) begin
          state_d = RUN;
        end else if (btn_lap && (lap_count != 4'd0)) begin
          state_d = REVIEW;
          sel_d   = 4'd1;
        end
      end

      REVIEW: begin
        if (btn_clear) begin
          clr_d   = 1'b1;
          empty_d = 1'b1;
          state_d = IDLE;
        end else if (btn_start) begin
          state_d = PAUSE;
        end else if (btn_lap) begin
          sel_d = (lap_sel == lap_count) ? 4'd1 : lap_sel + 4'd1;
        end else begin
          sel_d = lap_sel;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Lap age k lives k slots behind the write pointer; the ring wraps naturally.
  always_comb begin
    rd_idx = wr_ptr_q - sel_d[PTR_W-1:0];
  end

  // Output values for the next cycle, derived from the next state.
  always_comb begin
    en_d    = 1'b0;
    lap_d   = 1'b0;
    value_d = live_value;
    case (state_d)
      RUN: begin
        en_d = 1'b1;
      end
      LAP_HOLD: begin
        en_d    = 1'b1;
        lap_d   = 1'b1;
        value_d = capture ? live_value : hold_q;
      end
      REVIEW: begin
        lap_d   = 1'b1;
        value_d = mem[rd_idx];
      end
      default: begin
        value_d = live_value;
      end
    endcase
  end

  // State, registered outputs, lap bookkeeping and hold register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      count_en  <= 1'b0;
      count_clr <= 1'b0;
      value     <= 16'h0000;
      lap       <= 1'b0;
      lap_sel   <= 4'd0;
      lap_count <= 4'd0;
      wr_ptr_q  <= '0;
      hold_q    <= 16'h0000;
    end else begin
      state_q   <= state_d;
      count_en  <= en_d;
      count_clr <= clr_d;
      value     <= value_d;
      lap       <= lap_d;
      lap_sel   <= sel_d;

      if (empty_d) begin
        lap_count <= 4'd0;
        wr_ptr_q  <= '0;
      end else if (capture) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        if (lap_count != DEPTH_CNT) begin
          lap_count <= lap_count + 4'd1;
        end
      end

      if (capture) begin
        hold_q <= live_value;
      end
    end
  end

  // Lap ring storage; contents are only meaningful below lap_count.
  always_ff @(posedge clk) begin
    if (reset_n && capture) begin
      mem[wr_ptr_q] <= live_value;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_stop_watch_ctrl.sv
// Bench for stop_watch_ctrl: expected outputs are queued alongside each
// stimulus cycle and compared once the cycle's clock edge has passed.
module tb_stop_watch_ctrl;

  logic        clk;
  logic        reset_n;
  logic        btn_start;
  logic        btn_lap;
  logic        btn_clear;
  logic [15:0] live_value;
  logic        count_en;
  logic        count_clr;
  logic [15:0] value;
  logic        lap;
  logic [3:0]  lap_count;
  logic [3:0]  lap_sel;
  logic [2:0]  state;

  int n_checks = 0;
  int n_errors = 0;

  string       tag_q[$];
  int          fld_q[$];
  logic [15:0] val_q[$];

  stop_watch_ctrl #(.LAP_DEPTH(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .btn_start  (btn_start),
    .btn_lap    (btn_lap),
    .btn_clear  (btn_clear),
    .live_value (live_value),
    .count_en   (count_en),
    .count_clr  (count_clr),
    .value      (value),
    .lap        (lap),
    .lap_count  (lap_count),
    .lap_sel    (lap_sel),
    .state      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got 0x%04h want 0x%04h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] observe(input int fld);
    case (fld)
      0: observe = {13'd0, state};
      1: observe = {15'd0, count_en};
      2: observe = {15'd0, count_clr};
      3: observe = value;
      4: observe = {15'd0, lap};
      5: observe = {12'd0, lap_count};
      default: observe = {12'd0, lap_sel};
    endcase
  endfunction

  task automatic push(input string tag, input int fld, input logic [15:0] v);
    tag_q.push_back(tag);
    fld_q.push_back(fld);
    val_q.push_back(v);
  endtask

  // Queue the full expected output set for the cycle being driven.
  task automatic expect_all(input string tag, input logic [2:0] st, input logic en,
                            input logic clr, input logic [15:0] v, input logic lp,
                            input logic [3:0] cnt, input logic [3:0] sel);
    push({tag, ".state"}, 0, {13'd0, st});
    push({tag, ".count_en"}, 1, {15'd0, en});
    push({tag, ".count_clr"}, 2, {15'd0, clr});
    push({tag, ".value"}, 3, v);
    push({tag, ".lap"}, 4, {15'd0, lp});
    push({tag, ".lap_count"}, 5, {12'd0, cnt});
    push({tag, ".lap_sel"}, 6, {12'd0, sel});
  endtask

  task automatic drain();
    while (val_q.size() > 0) begin
      check_val(tag_q.pop_front(), observe(fld_q.pop_front()), val_q.pop_front());
    end
  endtask

  // Inputs change on the falling edge; results of the rising edge are
  // sampled at the next falling edge.
  task automatic cyc(input logic s, input logic l, input logic c, input logic [15:0] lv);
    btn_start  = s;
    btn_lap    = l;
    btn_clear  = c;
    live_value = lv;
    @(negedge clk);
    btn_start = 1'b0;
    btn_lap   = 1'b0;
    btn_clear = 1'b0;
    drain();
  endtask

  initial begin
    reset_n    = 1'b0;
    btn_start  = 1'b0;
    btn_lap    = 1'b0;
    btn_clear  = 1'b0;
    live_value = 16'h0000;

    // Reset with a start pulse present: reset must win.
    expect_all("rst", 3'd0, 1'b0, 1'b0, 16'h0000, 1'b0, 4'd0, 4'd0);
    cyc(1'b1, 1'b0, 1'b0, 16'h1234);
    reset_n = 1'b1;

    // Start, live value tracking, stop.
    expect_all("start", 3'd1, 1'b1, 1'b0, 16'h0000, 1'b0, 4'd0, 4'd0);
    cyc(1'b1, 1'b0, 1'b0, 16'h0000);
    expect_all("live12", 3'd1, 1'b1, 1'b0, 16'h0012, 1'b0, 4'd0, 4'd0);
    cyc(1'b0, 1'b0, 1'b0, 16'h0012);
    expect_all("stop", 3'd3, 1'b0, 1'b0, 16'h0013, 1'b0, 4'd0, 4'd0);
    cyc(1'b1, 1'b0, 1'b0, 16'h0013);

    // Lap hold and release by clear without clearing counters.
    expect_all("resume", 3'd1, 1'b1, 1'b0, 16'h0014, 1'b0, 4'd0, 4'd0);
    cyc(1'b1, 1'b0, 1'b0, 16'h0014);
    expect_all("lap345", 3'd2, 1'b1, 1'b0, 16'h0345, 1'b1, 4'd1, 4'd0);
    cyc(1'b0, 1'b1, 1'b0, 16'h0345);
    expect_all("hold345", 3'd2, 1'b1, 1'b0, 16'h0345, 1'b1, 4'd1, 4'd0);
    cyc(1'b0, 1'b0, 1'b0, 16'h0346);
    expect_all("release", 3'd1, 1'b1, 1'b0, 16'h0347, 1'b0, 4'd1, 4'd0);
    cyc(1'b0, 1'b0, 1'b1, 16'h0347);
    expect_all("live348", 3'd1, 1'b1, 1'b0, 16'h0348, 1'b0, 4'd1, 4'd0);
    cyc(1'b0, 1'b0, 1'b0, 16'h0348);

    // Pause, clear from PAUSE: one-cycle count_clr, memory emptied.
    expect_all("pause1", 3'd3, 1'b0, 1'b0, 16'h0349, 1'b0, 4'd1, 4'd0);
    cyc(1'b1, 1'b0, 1'b0, 16'h0349);
    expect_all("clr1", 3'd0, 1'b0, 1'b1, 16'h0349, 1'b0, 4'd0, 4'd0);
    cyc(1'b0, 1'b0, 1'b1, 16'h0349);
    expect_all("clr1_end", 3'd0, 1'b0, 1'b0, 16'h0000, 1'b0, 4'd0, 4'd0);
    cyc(1'b0, 1'b0, 1'b0, 16'h0000);

    // Lap in IDLE ignored; PAUSE with no laps ignores lap.
    expect_all("idle_lap", 3'd0, 1'b0, 1'b0, 16'h0000, 1'b0, 4'd0, 4'd0);
    cyc(1'b0, 1'b1, 1'b0, 16'h0000);
    expect_all("run2", 3'd1, 1'b1, 1'b0, 16'h0000, 1'b0, 4'd0, 4'd0);
    cyc(1'b1, 1'b0, 1'b0, 16'h0000);
    expect_all("pause2", 3'd3, 1'b0, 1'b0, 16'h0001, 1'b0, 4'd0, 4'd0);
    cyc(1'b1, 1'b0, 1'b0, 16'h0001);
    expect_all("empty_lap", 3'd3, 1'b0, 1'b0, 16'h0001, 1'b0, 4'd0, 4'd0);
    cyc(1'b0, 1'b1, 1'b0, 16'h0001);
    expect_all("clr2", 3'd0, 1'b0, 1'b1, 16'h0001, 1'b0, 4'd0, 4'd0);
    cyc(1'b0, 1'b0, 1'b1, 16'h0001);
    expect_all("clr2_end", 3'd0, 1'b0, 1'b0, 16'h0001, 1'b0, 4'd0, 4'd0);
    cyc(1'b0, 1'b0, 1'b0, 16'h0001);

    // Five laps into a four-deep ring, then review newest-first with wrap.
    expect_all("run3", 3'd1, 1'b1, 1'b0, 16'h0050, 1'b0, 4'd0, 4'd0);
    cyc(1'b1, 1'b0, 1'b0, 16'h0050);
    for (int i = 1; i <= 5; i++) begin
      logic [15:0] lv;
      lv = 16'h0101 * 16'(i);
      expect_all($sformatf("lap%0d", i), 3'd2, 1'b1, 1'b0, lv, 1'b1,
                 (i > 4) ? 4'd4 : 4'(i), 4'd0);
      cyc(1'b0, 1'b1, 1'b0, lv);
    end
    expect_all("pause3", 3'd3, 1'b0, 1'b0, 16'h0600, 1'b0, 4'd4, 4'd0);
    cyc(1'b1, 1'b0, 1'b0, 16'h0600);
    expect_all("rev1", 3'd4, 1'b0, 1'b0, 16'h0505, 1'b1, 4'd4, 4'd1);
    cyc(1'b0, 1'b1, 1'b0, 16'h0600);
    expect_all("rev2", 3'd4, 1'b0, 1'b0, 16'h0404, 1'b1, 4'd4, 4'd2);
    cyc(1'b0, 1'b1, 1'b0, 16'h0600);
    expect_all("rev_idle", 3'd4, 1'b0, 1'b0, 16'h0404, 1'b1, 4'd4, 4'd2);
    cyc(1'b0, 1'b0, 1'b0, 16'h0600);
    expect_all("rev3", 3'd4, 1'b0, 1'b0, 16'h0303, 1'b1, 4'd4, 4'd3);
    cyc(1'b0, 1'b1, 1'b0, 16'h0600);
    expect_all("rev4", 3'd4, 1'b0, 1'b0, 16'h0202, 1'b1, 4'd4, 4'd4);
    cyc(1'b0, 1'b1, 1'b0, 16'h0600);
    expect_all("rev_wrap", 3'd4, 1'b0, 1'b0, 16'h0505, 1'b1, 4'd4, 4'd1);
    cyc(1'b0, 1'b1, 1'b0, 16'h0600);
    expect_all("rev_exit", 3'd3, 1'b0, 1'b0, 16'h0600, 1'b0, 4'd4, 4'd0);
    cyc(1'b1, 1'b0, 1'b0, 16'h0600);

    // All three buttons together: start wins in RUN, clear wins in PAUSE.
    expect_all("run4", 3'd1, 1'b1, 1'b0, 16'h0601, 1'b0, 4'd4, 4'd0);
    cyc(1'b1, 1'b0, 1'b0, 16'h0601);
    expect_all("all_run", 3'd3, 1'b0, 1'b0, 16'h0777, 1'b0, 4'd4, 4'd0);
    cyc(1'b1, 1'b1, 1'b1, 16'h0777);
    expect_all("no_capture", 3'd4, 1'b0, 1'b0, 16'h0505, 1'b1, 4'd4, 4'd1);
    cyc(1'b0, 1'b1, 1'b0, 16'h0777);
    expect_all("pause4", 3'd3, 1'b0, 1'b0, 16'h0777, 1'b0, 4'd4, 4'd0);
    cyc(1'b1, 1'b0, 1'b0, 16'h0777);
    expect_all("all_pause", 3'd0, 1'b0, 1'b1, 16'h0777, 1'b0, 4'd0, 4'd0);
    cyc(1'b1, 1'b1, 1'b1, 16'h0777);

    // Reset during LAP_HOLD together with a lap pulse.
    expect_all("run5", 3'd1, 1'b1, 1'b0, 16'h0900, 1'b0, 4'd0, 4'd0);
    cyc(1'b1, 1'b0, 1'b0, 16'h0900);
    expect_all("lap999", 3'd2, 1'b1, 1'b0, 16'h0999, 1'b1, 4'd1, 4'd0);
    cyc(1'b0, 1'b1, 1'b0, 16'h0999);
    reset_n = 1'b0;
    expect_all("rst_hold", 3'd0, 1'b0, 1'b0, 16'h0000, 1'b0, 4'd0, 4'd0);
    cyc(1'b0, 1'b1, 1'b0, 16'h0a00);
    reset_n = 1'b1;
    expect_all("post_rst", 3'd0, 1'b0, 1'b0, 16'h0a01, 1'b0, 4'd0, 4'd0);
    cyc(1'b0, 1'b0, 1'b0, 16'h0a01);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
